pe_operand_feeder: RTL

Producer side of the PE operand interface. It pairs an IFM byte stream with a weight byte stream and drives one PE with `IFM`/`Weight` operands, one beat per cycle. It frames the beats into accumulation windows of `k_len` MACs, repeated `num_out` times, and marks window boundaries with `pe_clear`/`pe_last`. When no pair is transferred it drives zero operands, so an unconditionally accumulating PE adds nothing.

---
 rtl/pe_operand_feeder.sv | 113 +++++++++++
 1 files changed

// File: rtl/pe_operand_feeder.sv
// Producer side of the PE operand interface: joins an IFM and a weight byte
// stream into registered operand beats framed as k_len-long windows, num_out times.
module pe_operand_feeder #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  k_len,
  input  logic [CNT_W-1:0]  num_out,
  input  logic              ifm_valid,
  input  logic [DATA_W-1:0] ifm_data,
  output logic              ifm_ready,
  input  logic              wgt_valid,
  input  logic [DATA_W-1:0] wgt_data,
  output logic              wgt_ready,
  output logic [DATA_W-1:0] pe_ifm,
  output logic [DATA_W-1:0] pe_weight,
  output logic              pe_valid,
  output logic              pe_clear,
  output logic              pe_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, next_state;
  logic [CNT_W-1:0]  k_len_q, num_out_q;
  logic [CNT_W-1:0]  k_cnt, o_cnt;
  logic              in_run, xfer, k_wrap, last_window, accept;

  // Each stream's ready follows the other stream's valid, so neither is ever consumed alone.
  assign in_run      = (state == RUN);
  assign ifm_ready   = in_run & wgt_valid;
  assign wgt_ready   = in_run & ifm_valid;
  assign xfer        = in_run & ifm_valid & wgt_valid;
  assign k_wrap      = (k_cnt == k_len_q - CNT_W'(1));
  assign last_window = (o_cnt == num_out_q - CNT_W'(1));
  assign accept      = (state == IDLE) & start;
  assign busy        = (state != IDLE);
  assign done        = (state == DONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (k_len == '0 || num_out == '0) begin
            next_state = DONE;
          end else begin
            next_state = RUN;
          end
        end
      end
      RUN: begin
        if (xfer && k_wrap && last_window) begin
          next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      k_len_q   <= '0;
      num_out_q <= '0;
      k_cnt     <= '0;
      o_cnt     <= '0;
    end else if (accept) begin
      k_len_q   <= k_len;
      num_out_q <= num_out;
      k_cnt     <= '0;
      o_cnt     <= '0;
    end else if (xfer) begin
      if (k_wrap) begin
        k_cnt <= '0;
        o_cnt <= o_cnt + CNT_W'(1);
      end else begin
        k_cnt <= k_cnt + CNT_W'(1);
      end
    end
  end

  // Idle cycles register zero operands so an always-accumulating PE adds nothing.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pe_ifm    <= '0;
      pe_weight <= '0;
      pe_valid  <= 1'b0;
      pe_clear  <= 1'b0;
      pe_last   <= 1'b0;
    end else begin
      pe_ifm    <= xfer ? ifm_data : '0;
      pe_weight <= xfer ? wgt_data : '0;
      pe_valid  <= xfer;
      pe_clear  <= xfer & (k_cnt == '0);
      pe_last   <= xfer & k_wrap;
    end
  end

endmodule
